// File: rtl/cache_refill_ctrl_if.sv
// Bundle of the miss, memory, line-write and wait-buffer signals around the refill controller.
// master = refill controller side, slave = cache / memory / wait-buffer side.
interface cache_refill_ctrl_if #(
  parameter int ADDR_BITS   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int BLOCK_WIDTH = 256
);
  logic                   miss_valid;
  logic                   miss_ready;
  logic [ADDR_BITS-1:0]   miss_address;
  logic                   miss_pending_hit;
  logic                   mem_req_valid;
  logic                   mem_req_ready;
  logic [ADDR_BITS-1:0]   mem_req_address;
  logic                   mem_resp_valid;
  logic [DATA_WIDTH-1:0]  mem_resp_data;
  logic                   mem_resp_last;
  logic                   line_write_en;
  logic [ADDR_BITS-1:0]   line_write_address;
  logic [BLOCK_WIDTH-1:0] line_write_data;
  logic                   wb_search_invalidate;
  logic [ADDR_BITS-1:0]   wb_search_address;
  logic                   wb_in_walk_mode;
  logic                   busy;
  logic                   protocol_error;

  modport master (
    input  miss_valid, miss_address, mem_req_ready, mem_resp_valid,
           mem_resp_data, mem_resp_last, wb_in_walk_mode,
    output miss_ready, miss_pending_hit, mem_req_valid, mem_req_address,
           line_write_en, line_write_address, line_write_data,
           wb_search_invalidate, wb_search_address, busy, protocol_error
  );

  modport slave (
    output miss_valid, miss_address, mem_req_ready, mem_resp_valid,
           mem_resp_data, mem_resp_last, wb_in_walk_mode,
    input  miss_ready, miss_pending_hit, mem_req_valid, mem_req_address,
           line_write_en, line_write_address, line_write_data,
           wb_search_invalidate, wb_search_address, busy, protocol_error
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding cache line refill: miss -> burst read -> line write -> wait-buffer walk.
// Miss to line write is BEATS+2 cycles minimum; stalls on mem_req_ready, beat gaps and walk mode.
module cache_refill_ctrl #(
  parameter int ADDR_BITS      = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_WIDTH    = 256,
  parameter int BLOCK_ID_START = 5
) (
  input logic               clk,
  input logic               rst,
  cache_refill_ctrl_if.master bus
);
  localparam int BEATS = BLOCK_WIDTH / DATA_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_FILL, S_WRITE, S_LAUNCH, S_WALK_WAIT
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_cnt;
  logic [BLOCK_WIDTH-1:0] r_line;
  logic [ADDR_BITS-1:0]   r_addr;
  logic                   r_perr;

  logic                   w_busy;
  logic                   w_accept;
  logic                   w_beat;
  logic                   w_last_beat;
  logic                   w_beat_err;
  logic                   w_stray;
  logic [ADDR_BITS-1:0]   w_blk_addr;

  assign w_busy      = (r_state != S_IDLE);
  assign w_accept    = (r_state == S_IDLE) && bus.miss_valid;
  assign w_beat      = (r_state == S_FILL) && bus.mem_resp_valid;
  assign w_last_beat = (r_cnt == LAST_BEAT);
  // The beat count alone ends the fill; mem_resp_last is only cross-checked.
  assign w_beat_err  = w_beat && (bus.mem_resp_last != w_last_beat);
  assign w_stray     = bus.mem_resp_valid && (r_state != S_FILL);
  assign w_blk_addr  = {r_addr[ADDR_BITS-1:BLOCK_ID_START], {BLOCK_ID_START{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next                   = r_state;
    bus.miss_ready           = 1'b0;
    bus.mem_req_valid        = 1'b0;
    bus.line_write_en        = 1'b0;
    bus.wb_search_invalidate = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        bus.miss_ready = 1'b1;
        if (bus.miss_valid) w_next = S_REQ;
      end
      S_REQ: begin
        bus.mem_req_valid = 1'b1;
        if (bus.mem_req_ready) w_next = S_FILL;
      end
      S_FILL: begin
        if (w_beat && w_last_beat) w_next = S_WRITE;
      end
      S_WRITE: begin
        bus.line_write_en = 1'b1;
        w_next            = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.wb_search_invalidate = 1'b1;
        w_next                   = S_WALK_WAIT;
      end
      S_WALK_WAIT: begin
        if (!bus.wb_in_walk_mode) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_addr <= '0;
      r_perr <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr <= bus.miss_address;
        r_cnt  <= '0;
      end
      if (w_beat) begin
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CW'(k)) r_line[k*DATA_WIDTH +: DATA_WIDTH] <= bus.mem_resp_data;
        end
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_beat_err || w_stray) r_perr <= 1'b1;
    end
  end

  // Address-type outputs are held at zero while idle so IDLE presents an all-zero bus.
  assign bus.busy               = w_busy;
  assign bus.protocol_error     = r_perr;
  assign bus.mem_req_address    = w_busy ? w_blk_addr : '0;
  assign bus.line_write_address = w_busy ? w_blk_addr : '0;
  assign bus.line_write_data    = (r_state == S_WRITE) ? r_line : '0;
  assign bus.wb_search_address  = w_busy ? r_addr : '0;
  assign bus.miss_pending_hit   = w_busy &&
      (bus.miss_address[ADDR_BITS-1:BLOCK_ID_START] == r_addr[ADDR_BITS-1:BLOCK_ID_START]);
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: expected lines queued at stimulus, checked on line write.
module tb_cache_refill_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 256;
  localparam int NB = BW / DW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] line;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  cache_refill_ctrl_if #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW)) bus ();

  cache_refill_ctrl #(
    .ADDR_BITS(AW), .DATA_WIDTH(DW), .BLOCK_WIDTH(BW), .BLOCK_ID_START(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each line write, checks the walk pulse that follows.
  int            acc_cyc = 0;
  int            wr_cyc = 0;
  logic [AW-1:0] last_addr = '0;
  exp_t          cur;
  always @(negedge clk) begin
    if (!rst && bus.miss_valid && bus.miss_ready) acc_cyc = cyc;
    if (bus.line_write_en) begin
      wr_cyc = cyc;
      if (sb_q.size() == 0) check("sb_empty", 1, 0);
      else begin
        cur = sb_q.pop_front();
        check("line_data", bus.line_write_data, cur.line);
        check("line_addr", bus.line_write_address, {cur.addr[AW-1:5], 5'b0});
        check("latency", cyc - acc_cyc, cur.lat);
        last_addr = cur.addr;
      end
    end
    if (bus.wb_search_invalidate) begin
      check("pulse_cyc", cyc, wr_cyc + 1);
      check("wb_addr", bus.wb_search_address, last_addr);
    end
  end

  task automatic refill(input logic [AW-1:0] addr, input logic [BW-1:0] line,
                        input int req_dly, input logic [NB-1:0] gaps,
                        input int bad_beat, input int walk, input bit probe);
    exp_t          e;
    logic [AW-1:0] blk;
    int            n;
    blk    = {addr[AW-1:5], 5'b0};
    e.addr = addr;
    e.line = line;
    e.lat  = NB + 2 + req_dly + $countones(gaps);
    @(posedge clk); #1;
    bus.miss_valid   = 1'b1;
    bus.miss_address = addr;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.miss_valid = 1'b0;
    for (int i = 0; i < req_dly; i++) begin
      check("req_hold_vld", bus.mem_req_valid, 1);
      check("req_hold_addr", bus.mem_req_address, blk);
      if (probe && i < 2) begin
        bus.miss_address = blk + ((i == 0) ? 32'h1C : 32'h20);
        #1;
        check("pend_hit", bus.miss_pending_hit, (i == 0) ? 1 : 0);
        check("miss_rdy_busy", bus.miss_ready, 0);
      end
      @(posedge clk); #1;
    end
    check("req_vld", bus.mem_req_valid, 1);
    check("req_addr", bus.mem_req_address, blk);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = line[k*DW +: DW];
      bus.mem_resp_last  = (k == NB - 1) ^ (k == bad_beat);
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_last  = 1'b0;
      if (gaps[k]) begin
        @(posedge clk); #1;
      end
    end
    n = 0;
    while (!bus.wb_search_invalidate && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 40) check("pulse_timeout", 0, 1);
    for (int i = 0; i < walk; i++) begin
      @(posedge clk); #1;
      bus.wb_in_walk_mode = 1'b1;
      check("busy_walk", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.wb_in_walk_mode = 1'b0;
    check("busy_walk_end", bus.busy, 1);
    @(posedge clk); #1;
    check("idle_busy", bus.busy, 0);
    check("idle_miss_rdy", bus.miss_ready, 1);
    check("idle_req_vld", bus.mem_req_valid, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_miss_rdy"}, bus.miss_ready, 1);
    check({tag, "_req_vld"}, bus.mem_req_valid, 0);
    check({tag, "_req_addr"}, bus.mem_req_address, 0);
    check({tag, "_lwe"}, bus.line_write_en, 0);
    check({tag, "_inv"}, bus.wb_search_invalidate, 0);
    check({tag, "_wb_addr"}, bus.wb_search_address, 0);
    check({tag, "_perr"}, bus.protocol_error, 0);
  endtask

  function automatic logic [BW-1:0] rand_line();
    logic [BW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*DW +: DW] = $urandom;
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] l;
    rst                 = 1'b1;
    bus.miss_valid      = 1'b0;
    bus.miss_address    = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_resp_valid  = 1'b0;
    bus.mem_resp_data   = '0;
    bus.mem_resp_last   = 1'b0;
    bus.wb_in_walk_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;

    for (int k = 0; k < NB; k++) l[k*DW +: DW] = 32'h11 * (k + 1);
    refill(32'h1014, l, 0, 8'h00, -1, 0, 1'b0);
    check("perr_clean", bus.protocol_error, 0);

    refill(32'h0000_5A44, rand_line(), 5, 8'b0001_0010, -1, 4, 1'b0);
    refill(32'h2004, rand_line(), 3, 8'h00, -1, 1, 1'b1);
    check("perr_clean2", bus.protocol_error, 0);

    refill(32'h0000_7FE0, rand_line(), 0, 8'h04, 3, 0, 1'b0);
    check("perr_last_early", bus.protocol_error, 1);
    repeat (2) @(posedge clk);
    #1;
    check("perr_sticky", bus.protocol_error, 1);

    // Reset in the middle of a fill: no line write may follow.
    @(posedge clk); #1;
    bus.miss_valid   = 1'b1;
    bus.miss_address = 32'h3008;
    @(posedge clk); #1;
    bus.miss_valid    = 1'b0;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_data  = $urandom;
      @(posedge clk); #1;
    end
    bus.mem_resp_valid = 1'b0;
    check("mid_fill_busy", bus.busy, 1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    refill(32'h3008, rand_line(), 1, 8'h00, -1, 0, 1'b0);
    check("perr_after_rst", bus.protocol_error, 0);

    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    bus.mem_resp_valid = 1'b0;
    check("perr_stray", bus.protocol_error, 1);
    check("stray_busy", bus.busy, 0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
